// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD controller: state encoding, init table, lcd bit map.
package lcd_pkg;

  typedef enum logic [2:0] {ST_WAIT, ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  localparam int INIT_LEN = 8;
  localparam int IDX_W    = 3;
  // First byte sent sits in the top octet.
  localparam logic [INIT_LEN*8-1:0] INIT_TABLE = 64'hA2A0_C82F_2681_10AF;

  localparam int LCD_CS  = 0;
  localparam int LCD_SCL = 1;
  localparam int LCD_A0  = 2;
  localparam int LCD_SI  = 3;

  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
    return INIT_TABLE[8*(INIT_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/lcd_spi_tx.sv
// One-byte serializer: CS low for 16 SCL half-periods, MSB first, SI moves on SCL fall.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       a0_in,
  output logic       done,
  output logic [3:0] lcd
);

  logic        active;
  logic [15:0] div_cnt;
  logic [3:0]  half;
  logic [7:0]  shreg;
  logic        cs, scl, a0, si;

  assign done = active && (div_cnt == 16'(CLK_DIV - 1)) && (half == 4'd15);

  assign lcd[LCD_CS]  = cs;
  assign lcd[LCD_SCL] = scl;
  assign lcd[LCD_A0]  = a0;
  assign lcd[LCD_SI]  = si;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      half    <= '0;
      shreg   <= '0;
      cs      <= 1'b1;
      scl     <= 1'b1;
      a0      <= 1'b1;
      si      <= 1'b1;
    end else if (start && !active) begin
      // First half-period is SCL low with bit 7 already on SI.
      active  <= 1'b1;
      div_cnt <= '0;
      half    <= '0;
      shreg   <= {byte_in[6:0], 1'b0};
      si      <= byte_in[7];
      scl     <= 1'b0;
      cs      <= 1'b0;
      a0      <= a0_in;
    end else if (active) begin
      if (div_cnt == 16'(CLK_DIV - 1)) begin
        div_cnt <= '0;
        if (half == 4'd15) begin
          active <= 1'b0;
          cs     <= 1'b1;
          scl    <= 1'b1;
          si     <= 1'b1;
        end else begin
          half <= half + 4'd1;
          scl  <= ~scl;
          if (scl) begin
            si    <= shreg[7];
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_ctrl_sched.sv
// LCD command/data scheduler over a write-only SPI link.
// Define LCD_CTRL_INIT_EN to send the init table after power-up; otherwise ready right after reset.
module lcd_ctrl_sched
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 250,
  parameter int PWRUP_WAIT = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       dat_valid,
  input  logic [7:0] dat_byte,
  output logic       dat_ready,
  output logic       busy,
  output logic       init_done,
  output logic [3:0] lcd
);

  state_t           state;
  logic             rdy;
  logic [IDX_W-1:0] idx;
  logic [15:0]      gap_cnt;
  logic             hs_cmd, hs_dat, start, done, tx_a0;
  logic [7:0]       tx_byte;
`ifdef LCD_CTRL_INIT_EN
  logic [31:0]      wait_cnt;
`endif

  // rdy is only ever set on entry to IDLE, so a handshake implies IDLE.
  assign cmd_ready = rdy;
  assign dat_ready = rdy && !cmd_valid;
  assign hs_cmd    = rdy && cmd_valid;
  assign hs_dat    = rdy && dat_valid && !cmd_valid;

  assign start   = (state == ST_INIT) || hs_cmd || hs_dat;
  assign tx_a0   = hs_dat;
  assign tx_byte = (state == ST_INIT) ? init_byte(idx) : (hs_cmd ? cmd_byte : dat_byte);

  lcd_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .byte_in (tx_byte),
    .a0_in   (tx_a0),
    .done    (done),
    .lcd     (lcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      rdy       <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      idx       <= '0;
      gap_cnt   <= '0;
`ifdef LCD_CTRL_INIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_WAIT: begin
`ifdef LCD_CTRL_INIT_EN
          if (wait_cnt == 32'(PWRUP_WAIT - 1)) state <= ST_INIT;
          else wait_cnt <= wait_cnt + 32'd1;
`else
          state     <= ST_IDLE;
          busy      <= 1'b0;
          rdy       <= 1'b1;
          init_done <= 1'b1;
`endif
        end
        ST_INIT: state <= ST_SHIFT;
        ST_IDLE: begin
          if (hs_cmd || hs_dat) begin
            state <= ST_SHIFT;
            rdy   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (done) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(CLK_DIV - 1)) begin
            if (!init_done && idx != IDX_W'(INIT_LEN - 1)) begin
              idx   <= idx + 1'b1;
              state <= ST_INIT;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              rdy       <= 1'b1;
              init_done <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_sched.sv
// Scoreboard bench: expected {a0,byte} queued at handshake, checked when CS rises on the lcd bus.
module tb_lcd_ctrl_sched;
  import lcd_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int PWRUP_WAIT = 10;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, dat_valid = 1'b0;
  logic [7:0] cmd_byte = '0, dat_byte = '0;
  logic       cmd_ready, dat_ready, busy, init_done;
  logic [3:0] lcd;

  lcd_ctrl_sched #(.CLK_DIV(CLK_DIV), .PWRUP_WAIT(PWRUP_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .dat_valid(dat_valid), .dat_byte(dat_byte), .dat_ready(dat_ready),
    .busy(busy), .init_done(init_done), .lcd(lcd)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor
  int         nb = 0, cs_len = 0, scl_falls = 0, cs_rise_cyc = 0;
  logic [7:0] bits = '0;
  logic       a0_first = 1'b0, a0_chg = 1'b0;
  bit         abort_ok = 1'b0;
  logic [3:0] prev = 4'hF;
  logic [8:0] e;

  always @(negedge clk) begin
    if (prev[LCD_SCL] === 1'b1 && lcd[LCD_SCL] === 1'b0) scl_falls++;
    if (prev[LCD_CS] === 1'b1 && lcd[LCD_CS] === 1'b0) begin
      nb = 0; bits = '0; cs_len = 0; a0_first = lcd[LCD_A0]; a0_chg = 1'b0;
    end
    if (lcd[LCD_CS] === 1'b0) begin
      cs_len++;
      if (lcd[LCD_A0] !== a0_first) a0_chg = 1'b1;
      if (prev[LCD_SCL] === 1'b0 && lcd[LCD_SCL] === 1'b1) begin
        bits = {bits[6:0], lcd[LCD_SI]};
        nb++;
      end
    end
    if (prev[LCD_CS] === 1'b0 && lcd[LCD_CS] === 1'b1) begin
      cs_rise_cyc = cyc;
      if (!(abort_ok && nb != 8)) begin
        if (exp_q.size() == 0) chk("sb_extra", {a0_first, bits}, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("byte", {a0_first, bits}, e);
        end
        chk("nbits", nb, 8);
        chk("cs_len", cs_len, 16 * CLK_DIV);
        chk("a0_stable", a0_chg, 0);
      end
    end
    prev = lcd;
  end

  task automatic push_init();
    for (int i = 0; i < INIT_LEN; i++) exp_q.push_back({1'b0, init_byte(3'(i))});
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
    chk(tag, init_done, 1);
  endtask

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
    chk(tag, cmd_ready, 1);
  endtask

  task automatic send(input bit d, input logic [7:0] b, input bit expect_it);
    int n = 0;
    @(negedge clk);
    if (d) begin dat_valid = 1'b1; dat_byte = b; end
    else   begin cmd_valid = 1'b1; cmd_byte = b; end
    if (expect_it) exp_q.push_back({d, b});
    #1;
    while (!(d ? dat_ready : cmd_ready) && n < 2000) begin @(negedge clk); #1; n++; end
    if (n >= 2000) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; dat_valid = 1'b0;
  endtask

  int sf;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd", lcd, 4'hF);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_dat_ready", dat_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);

`ifdef LCD_CTRL_INIT_EN
    push_init();
    rst_n = 1'b1;
    wait_init("init_timeout");
    chk("init_gap", cyc - cs_rise_cyc, CLK_DIV);
    chk("init_busy", busy, 0);
    chk("init_q", exp_q.size(), 0);
`else
    rst_n = 1'b1;
    sf = scl_falls;
    @(posedge clk); #1;
    chk("off_init_done", init_done, 1);
    chk("off_cmd_ready", cmd_ready, 1);
    chk("off_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("off_no_scl", scl_falls - sf, 0);
`endif

    // Single command
    send(1'b0, 8'hB3, 1'b1);
    chk("rdy_drop", cmd_ready, 0);
    chk("busy_hs", busy, 1);
    wait_cmd_ready("cmd_timeout");
    chk("ready_gap", cyc - cs_rise_cyc, CLK_DIV);
    chk("cmd_q", exp_q.size(), 0);

    // Simultaneous command and data
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = 8'h40;
    dat_valid = 1'b1; dat_byte = 8'h55;
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b1, 8'h55});
    #1;
    chk("prio_cmd_ready", cmd_ready, 1);
    chk("prio_dat_ready", dat_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("prio_dat_held", dat_ready, 0);
    begin
      int n = 0;
      while (dat_ready !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
      chk("dat_timeout", dat_ready, 1);
    end
    @(posedge clk); #1;
    dat_valid = 1'b0;
    wait_cmd_ready("simul_timeout");
    chk("simul_q", exp_q.size(), 0);

    // Reset in the middle of 0xFF
    abort_ok = 1'b1;
    send(1'b0, 8'hFF, 1'b0);
    begin
      int n = 0;
      while (nb != 3 && n < 2000) begin @(negedge clk); #1; n++; end
      chk("bit3_timeout", nb, 3);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_lcd", lcd, 4'hF);
    chk("abort_init_done", init_done, 0);
    @(posedge clk);
    @(negedge clk);
`ifdef LCD_CTRL_INIT_EN
    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    abort_ok = 1'b0;
    wait_init("reinit_timeout");
    chk("reinit_q", exp_q.size(), 0);
`else
    rst_n = 1'b1;
    sf = scl_falls;
    @(posedge clk); #1;
    chk("reoff_cmd_ready", cmd_ready, 1);
    abort_ok = 1'b0;
    repeat (30) @(negedge clk);
    chk("reoff_no_scl", scl_falls - sf, 0);
`endif

    repeat (5) @(negedge clk);
    chk("final_q", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
